// File: rtl/adder_seq.sv
// Multi-cycle N-bit adder, K bits per cycle, valid/ready on both sides.
// Define ADDER_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module adder_seq #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         co
`ifdef ADDER_SEQ_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int C  = (K > 0) ? N / K : 1;
  localparam int IW = (C > 1) ? $clog2(C) : 1;
  localparam logic [IW-1:0] LAST = IW'(C - 1);

  generate
    if (K < 1 || K > N || (N % ((K > 0) ? K : 1)) != 0) begin : g_bad_param
      $error("adder_seq: need 1 <= K <= N and N a multiple of K");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          co_q, co_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [K-1:0]  ach, bch, s;
  logic          c;

`ifdef ADDER_SEQ_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  always_comb begin
    ach    = a_q[int'(idx_q)*K +: K];
    bch    = b_q[int'(idx_q)*K +: K];
    {c, s} = {1'b0, ach} + {1'b0, bch} + {{K{1'b0}}, carry_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    co_d    = co_q;
    idx_d   = idx_q;
`ifdef ADDER_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*K +: K] = s;
        carry_d = c;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          co_d    = c;
`ifdef ADDER_SEQ_OVF_EN
          // carry into MSB is recovered from the MSB sum bit
          ovf_d   = s[K-1] ^ ach[K-1] ^ bch[K-1] ^ c;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      idx_q   <= '0;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      idx_q   <= idx_d;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign co        = co_q;
`ifdef ADDER_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_adder_seq.sv
// Testbench for adder_seq: instances with K=4, K=1 and K=16 at N=16.
// Scoreboarded results; ovf is checked when ADDER_SEQ_OVF_EN is defined.
module tb_adder_seq;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         ci = 1'b0;
  logic         iv[3];
  logic         ordy[3];
  logic         ir[3];
  logic         ov[3];
  logic         co_w[3];
  logic         of_w[3];
  logic [N-1:0] s_w[3];

  int cyc = 0;
  int passed = 0;
  int total = 0;
  int t_acc = 0;

  typedef struct packed {
    logic [N-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int KG = (g == 0) ? 4 : (g == 1) ? 1 : 16;
      adder_seq #(.N(N), .K(KG)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (iv[g]),
        .in_ready (ir[g]),
        .a        (a),
        .b        (b),
        .ci       (ci),
        .out_valid(ov[g]),
        .out_ready(ordy[g]),
        .sum      (s_w[g]),
        .co       (co_w[g])
`ifdef ADDER_SEQ_OVF_EN
        ,
        .ovf      (of_w[g])
`endif
      );
`ifndef ADDER_SEQ_OVF_EN
      assign of_w[g] = 1'b0;
`endif
    end
  endgenerate

  function automatic int lat(int u);
    return (u == 0) ? 4 : (u == 1) ? 16 : 1;
  endfunction

  task automatic issue(int u, logic [N-1:0] x, logic [N-1:0] y, logic c);
    exp_t e;
    logic [N:0] f;
    f = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
    e.s = f[N-1:0];
    e.c = f[N];
    e.o = (x[N-1] == y[N-1]) && (f[N-1] != x[N-1]);
    sb.push_back(e);
    @(negedge clk);
    for (int k = 0; k < 60 && !ir[u]; k++) @(negedge clk);
    if (!ir[u]) begin
      total++;
      $display("FAIL accept_wait u=%0d in_ready=%b required 1", u, ir[u]);
    end
    a = x;
    b = y;
    ci = c;
    iv[u] = 1'b1;
    @(posedge clk);
    #1;
    t_acc = cyc;
    @(negedge clk);
    iv[u] = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
    ci = 1'($urandom);
  endtask

  task automatic collect(int u, bit chk_lat);
    exp_t e;
    for (int k = 0; k < 60 && !ov[u]; k++) @(negedge clk);
    total++;
    if (!ov[u]) begin
      $display("FAIL result_wait u=%0d out_valid=%b required 1", u, ov[u]);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (chk_lat) begin
      if ((cyc - t_acc) !== lat(u))
        $display("FAIL latency u=%0d got %0d required %0d",
                 u, cyc - t_acc, lat(u));
      else passed++;
    end else begin
      passed++;
    end
    e = sb.pop_front();
    total++;
    if (s_w[u] !== e.s)
      $display("FAIL sum u=%0d got %h required %h", u, s_w[u], e.s);
    else passed++;
    total++;
    if (co_w[u] !== e.c)
      $display("FAIL co u=%0d got %b required %b", u, co_w[u], e.c);
    else passed++;
`ifdef ADDER_SEQ_OVF_EN
    total++;
    if (of_w[u] !== e.o)
      $display("FAIL ovf u=%0d got %b required %b", u, of_w[u], e.o);
    else passed++;
`endif
    ordy[u] = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (ov[u] !== 1'b0 || ir[u] !== 1'b1)
      $display("FAIL release u=%0d out_valid=%b in_ready=%b required 0/1",
               u, ov[u], ir[u]);
    else passed++;
    @(negedge clk);
    ordy[u] = 1'b0;
  endtask

  task automatic run_op(int u, logic [N-1:0] x, logic [N-1:0] y, logic c);
    issue(u, x, y, c);
    collect(u, 1'b1);
  endtask

  task automatic test_reset;
    #3 rst = 1'b1;
    #2;
    for (int u = 0; u < 3; u++) begin
      total++;
      if (s_w[u] !== '0 || co_w[u] !== 1'b0 || ov[u] !== 1'b0 ||
          ir[u] !== 1'b1 || of_w[u] !== 1'b0)
        $display("FAIL reset u=%0d sum=%h co=%b ov=%b ir=%b ovf=%b required 0/0/0/1/0",
                 u, s_w[u], co_w[u], ov[u], ir[u], of_w[u]);
      else passed++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    run_op(0, 16'h1234, 16'h0FFF, 1'b0);
  endtask

  task automatic test_carry;
    run_op(0, 16'hFFFF, 16'hFFFF, 1'b1);
    run_op(0, 16'hFFFF, 16'h0001, 1'b0);
  endtask

  task automatic test_backpressure;
    issue(0, 16'h0F0F, 16'h00F1, 1'b1);
    for (int k = 0; k < 60 && !ov[0]; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || s_w[0] !== sb[0].s ||
          co_w[0] !== sb[0].c)
        $display("FAIL hold k=%0d ov=%b ir=%b sum=%h co=%b required 1/0/%h/%b",
                 k, ov[0], ir[0], s_w[0], co_w[0], sb[0].s, sb[0].c);
      else passed++;
      if (k == 2) begin
        a = 16'hAAAA;
        iv[0] = 1'b1;
      end
      if (k == 3) iv[0] = 1'b0;
      @(negedge clk);
    end
    collect(0, 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1)
      $display("FAIL idle_after u=0 ov=%b ir=%b required 0/1", ov[0], ir[0]);
    else passed++;
  endtask

  task automatic test_reset_mid_run;
    issue(0, 16'h1234, 16'h0FFF, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (s_w[0] !== '0 || co_w[0] !== 1'b0 || ov[0] !== 1'b0 ||
        ir[0] !== 1'b1 || of_w[0] !== 1'b0)
      $display("FAIL mid_reset sum=%h co=%b ov=%b ir=%b ovf=%b required 0/0/0/1/0",
               s_w[0], co_w[0], ov[0], ir[0], of_w[0]);
    else passed++;
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 16'h0001, 16'h0002, 1'b0);
  endtask

  task automatic test_ovf;
    run_op(0, 16'h7FFF, 16'h0001, 1'b0);
    run_op(0, 16'h8000, 16'h8000, 1'b0);
    run_op(0, 16'h1234, 16'h0FFF, 1'b0);
  endtask

  task automatic test_sweep;
    for (int u = 0; u < 3; u++)
      for (int n = 0; n < 100; n++)
        run_op(u, N'($urandom), N'($urandom), 1'($urandom));
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      iv[u] = 1'b0;
      ordy[u] = 1'b0;
    end
    test_reset;
    test_basic;
    test_carry;
    test_backpressure;
    test_reset_mid_run;
    test_ovf;
    test_sweep;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
